// File: rtl/lpif_state_ctrl.sv
// LPIF RX state controller: tracks LTSSM state and negotiated rate, drives pl_state_sts/pl_speedmode,
// runs the stall handshake ahead of a rate change and gates the RX datapath.
module lpif_state_ctrl #(
    parameter int LINKUP_CYCLES = 4,
    parameter int STALL_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] ltssm_state,
    input  logic [2:0] GEN,
    input  logic [3:0] lp_state_req,
    input  logic       lp_force_detect,
    input  logic       lp_stallack,
    output logic [3:0] pl_state_sts,
    output logic [2:0] pl_speedmode,
    output logic       pl_inband_pres,
    output logic       pl_stallreq,
    output logic       rx_enable,
    output logic       ltssmForceDetect
);

    localparam logic [3:0] LTSSM_DETECT   = 4'd0;
    localparam logic [3:0] LTSSM_L0       = 4'd3;
    localparam logic [3:0] LTSSM_RECOVERY = 4'd4;

    localparam logic [3:0] STS_RESET     = 4'b0000;
    localparam logic [3:0] STS_ACTIVE    = 4'b0001;
    localparam logic [3:0] STS_RETRAIN   = 4'b1001;
    localparam logic [3:0] STS_LINKRESET = 4'b1011;
    localparam logic [3:0] STS_DISABLED  = 4'b1111;

    localparam logic [3:0] REQ_NOP      = 4'b0000;
    localparam logic [3:0] REQ_ACTIVE   = 4'b0001;
    localparam logic [3:0] REQ_DISABLED = 4'b1111;

    localparam int LW = $clog2(LINKUP_CYCLES + 1);
    localparam logic [LW-1:0] LINKUP_LAST = LW'(LINKUP_CYCLES - 1);
    localparam logic [7:0]    STALL_LAST  = 8'(STALL_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_RESET,
        ST_ACTIVE,
        ST_RETRAIN,
        ST_STALL,
        ST_LINKRESET,
        ST_DISABLED
    } state_t;

    state_t          state_reg;
    logic [LW-1:0]   linkup_cnt_reg;
    logic [7:0]      stall_cnt_reg;

    // Rates 0, 6 and 7 are illegal and never reach pl_speedmode.
    logic gen_legal;
    assign gen_legal = (GEN >= 3'd1) && (GEN <= 3'd5);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg        <= ST_RESET;
            linkup_cnt_reg   <= '0;
            stall_cnt_reg    <= '0;
            pl_state_sts     <= STS_RESET;
            pl_speedmode     <= 3'd1;
            pl_inband_pres   <= 1'b0;
            pl_stallreq      <= 1'b0;
            rx_enable        <= 1'b0;
            ltssmForceDetect <= 1'b0;
        end else begin
            pl_inband_pres <= (ltssm_state == LTSSM_L0);
            if (lp_force_detect && state_reg != ST_DISABLED) begin
                state_reg        <= ST_LINKRESET;
                pl_state_sts     <= STS_LINKRESET;
                ltssmForceDetect <= 1'b1;
                pl_stallreq      <= 1'b0;
                rx_enable        <= 1'b0;
                linkup_cnt_reg   <= '0;
                stall_cnt_reg    <= '0;
            end else if (ltssm_state == LTSSM_DETECT &&
                         (state_reg == ST_ACTIVE || state_reg == ST_RETRAIN ||
                          state_reg == ST_STALL)) begin
                state_reg        <= ST_LINKRESET;
                pl_state_sts     <= STS_LINKRESET;
                ltssmForceDetect <= 1'b0;
                pl_stallreq      <= 1'b0;
                rx_enable        <= 1'b0;
                linkup_cnt_reg   <= '0;
                stall_cnt_reg    <= '0;
            end else begin
                case (state_reg)
                    ST_RESET: begin
                        if (ltssm_state == LTSSM_L0 && lp_state_req == REQ_ACTIVE) begin
                            if (linkup_cnt_reg == LINKUP_LAST) begin
                                state_reg      <= ST_ACTIVE;
                                pl_state_sts   <= STS_ACTIVE;
                                rx_enable      <= 1'b1;
                                linkup_cnt_reg <= '0;
                                if (gen_legal)
                                    pl_speedmode <= GEN;
                            end else begin
                                linkup_cnt_reg <= linkup_cnt_reg + LW'(1);
                            end
                        end else begin
                            linkup_cnt_reg <= '0;
                        end
                    end
                    ST_ACTIVE: begin
                        if (lp_state_req == REQ_DISABLED) begin
                            state_reg    <= ST_DISABLED;
                            pl_state_sts <= STS_DISABLED;
                            rx_enable    <= 1'b0;
                        end else if (ltssm_state == LTSSM_RECOVERY) begin
                            state_reg    <= ST_RETRAIN;
                            pl_state_sts <= STS_RETRAIN;
                            rx_enable    <= 1'b0;
                        end
                    end
                    ST_RETRAIN: begin
                        if (ltssm_state == LTSSM_L0) begin
                            // An illegal GEN counts as "same rate" so no stall is started.
                            if (!gen_legal || GEN == pl_speedmode) begin
                                state_reg    <= ST_ACTIVE;
                                pl_state_sts <= STS_ACTIVE;
                                rx_enable    <= 1'b1;
                            end else begin
                                state_reg     <= ST_STALL;
                                pl_state_sts  <= STS_RETRAIN;
                                pl_stallreq   <= 1'b1;
                                stall_cnt_reg <= '0;
                            end
                        end
                    end
                    ST_STALL: begin
                        if (lp_stallack) begin
                            state_reg    <= ST_ACTIVE;
                            pl_state_sts <= STS_ACTIVE;
                            pl_stallreq  <= 1'b0;
                            rx_enable    <= 1'b1;
                            if (gen_legal)
                                pl_speedmode <= GEN;
                        end else if (stall_cnt_reg == STALL_LAST) begin
                            state_reg     <= ST_LINKRESET;
                            pl_state_sts  <= STS_LINKRESET;
                            pl_stallreq   <= 1'b0;
                            stall_cnt_reg <= '0;
                        end else begin
                            stall_cnt_reg <= stall_cnt_reg + 8'd1;
                        end
                    end
                    ST_LINKRESET: begin
                        ltssmForceDetect <= 1'b0;
                        if (ltssm_state == LTSSM_DETECT) begin
                            state_reg      <= ST_RESET;
                            pl_state_sts   <= STS_RESET;
                            linkup_cnt_reg <= '0;
                            stall_cnt_reg  <= '0;
                        end
                    end
                    ST_DISABLED: begin
                        if (lp_state_req == REQ_NOP) begin
                            state_reg      <= ST_RESET;
                            pl_state_sts   <= STS_RESET;
                            linkup_cnt_reg <= '0;
                        end
                    end
                    default: begin
                        state_reg    <= ST_RESET;
                        pl_state_sts <= STS_RESET;
                        pl_stallreq  <= 1'b0;
                        rx_enable    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
